// File: rtl/mmio_pkg.sv
// Shared address map, FSM states and region decode for the MMIO bridge.
package mmio_pkg;

    localparam int unsigned RAM_BASE    = 'h0000;
    localparam int unsigned HEX_BASE    = 'hF000;
    localparam int unsigned LED_ADDR    = 'hF100;
    localparam int unsigned SW_ADDR     = 'hF200;
    localparam int unsigned KEY_ADDR    = 'hF300;
    localparam int unsigned KEYCAP_ADDR = 'hF301;
    localparam int unsigned TIMER_LO    = 'hF400;
    localparam int unsigned TIMER_HI    = 'hF401;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        R_RAM,
        R_HEX,
        R_LED,
        R_SW,
        R_KEY,
        R_KEYCAP,
        R_TIMER,
        R_NONE
    } region_e;

    // I/O windows are checked before RAM so a large RAM never shadows them.
    function automatic region_e decode(input logic [31:0] addr, input int unsigned ram_depth,
                                       input int unsigned num_hex, input bit timer_en);
        region_e r;
        if (addr >= HEX_BASE && addr < HEX_BASE + num_hex) r = R_HEX;
        else if (addr == LED_ADDR) r = R_LED;
        else if (addr == SW_ADDR) r = R_SW;
        else if (addr == KEY_ADDR) r = R_KEY;
        else if (addr == KEYCAP_ADDR) r = R_KEYCAP;
        else if (timer_en && (addr == TIMER_LO || addr == TIMER_HI)) r = R_TIMER;
        else if (addr >= RAM_BASE && addr < RAM_BASE + ram_depth) r = R_RAM;
        else r = R_NONE;
        return r;
    endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// Processor data-port bundle: request/done handshake with address and data.
interface mmio_bridge_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              ReadData;
    logic              WriteData;
    logic [ADDR_W-1:0] DataAddr;
    logic [DATA_W-1:0] DataOut;
    logic [DATA_W-1:0] DataIn;
    logic              DataDone;

    modport master(output ReadData, WriteData, DataAddr, DataOut, input DataIn, DataDone);
    modport slave(input ReadData, WriteData, DataAddr, DataOut, output DataIn, DataDone);
endinterface

// File: rtl/mmio_sync_edge.sv
// Two-flop synchroniser for asynchronous inputs with a registered rising-edge detect.
module mmio_sync_edge #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] level_o,
    output logic [Width-1:0] rise_o
);
    logic [Width-1:0] meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
endmodule

// File: rtl/mmio_bridge.sv
// Processor data-port bridge to on-chip RAM and board I/O (HEX, LEDR, SW, KEY).
// Define MMIO_TIMER_EN to add a 32-bit free-running cycle counter at 0xF400/0xF401.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned RAM_AW      = 12,
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned NUM_HEX     = 6,
    parameter int unsigned NUM_LED     = 10,
    parameter int unsigned NUM_SW      = 10,
    parameter int unsigned NUM_KEY     = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    mmio_bridge_if.slave            bus_io,
    output logic [NUM_HEX-1:0][6:0] HEX,
    output logic [NUM_LED-1:0]      LEDR,
    input  logic [NUM_SW-1:0]       SW,
    input  logic [NUM_KEY-1:0]      KEY
);
    localparam int unsigned RamDepth = 2 ** RAM_AW;
`ifdef MMIO_TIMER_EN
    localparam bit TimerEn = 1'b1;
`else
    localparam bit TimerEn = 1'b0;
`endif

    logic [DATA_W-1:0] mem [RamDepth];

    state_e                    state_q;
    logic [3:0]                cnt_q;
    logic                      done_q;
    logic                      rd_q;
    logic [DATA_W-1:0]         din_q;
    logic [DATA_W-1:0]         rdata_q;
    logic [NUM_HEX-1:0][6:0]   hex_q;
    logic [NUM_LED-1:0]        led_q;
    logic [NUM_KEY-1:0]        cap_q;

    logic [NUM_SW-1:0]  sw_lvl;
    logic [NUM_SW-1:0]  unused_sw_rise;
    logic [NUM_KEY-1:0] key_lvl;
    logic [NUM_KEY-1:0] key_rise;
    logic [NUM_KEY-1:0] cap_clr;

    logic              req, wr_acc, rd_acc;
    logic [31:0]       addr32, hex_off;
    logic [RAM_AW-1:0] ram_idx;
    logic [DATA_W-1:0] rd_val;
    region_e           region;

    mmio_sync_edge #(.Width(NUM_SW)) u_sw_sync (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .d_i    (SW),
        .level_o(sw_lvl),
        .rise_o (unused_sw_rise)
    );

    // Keys are active-low; synchronise the pressed sense so a press is a rising edge.
    mmio_sync_edge #(.Width(NUM_KEY)) u_key_sync (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .d_i    (~KEY),
        .level_o(key_lvl),
        .rise_o (key_rise)
    );

    assign req     = bus_io.ReadData | bus_io.WriteData;
    assign wr_acc  = (state_q == IDLE) && bus_io.WriteData;
    assign rd_acc  = (state_q == IDLE) && bus_io.ReadData && !bus_io.WriteData;
    assign addr32  = 32'(bus_io.DataAddr);
    assign hex_off = addr32 - HEX_BASE;
    assign ram_idx = bus_io.DataAddr[RAM_AW-1:0];
    assign region  = decode(addr32, RamDepth, NUM_HEX, TimerEn);
    assign cap_clr = (wr_acc && region == R_KEYCAP) ? NUM_KEY'(bus_io.DataOut) : '0;

`ifdef MMIO_TIMER_EN
    logic [31:0] tmr_q;
    logic [15:0] snap_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tmr_q  <= '0;
            snap_q <= '0;
        end else begin
            if (wr_acc && region == R_TIMER && !addr32[0]) tmr_q <= '0;
            else tmr_q <= tmr_q + 32'd1;
            if (rd_acc && region == R_TIMER && !addr32[0]) snap_q <= tmr_q[31:16];
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        unique case (region)
            R_RAM: rd_val = mem[ram_idx];
            R_HEX: begin
                for (int i = 0; i < NUM_HEX; i++) begin
                    if (hex_off == 32'(i)) rd_val = DATA_W'(hex_q[i]);
                end
            end
            R_LED:    rd_val = DATA_W'(led_q);
            R_SW:     rd_val = DATA_W'(sw_lvl);
            R_KEY:    rd_val = DATA_W'(key_lvl);
            R_KEYCAP: rd_val = DATA_W'(cap_q);
`ifdef MMIO_TIMER_EN
            R_TIMER:  rd_val = addr32[0] ? DATA_W'(snap_q) : DATA_W'(tmr_q[15:0]);
`endif
            default:  rd_val = '0;
        endcase
    end

    // RAM has no reset; a write coinciding with Reset is dropped.
    always_ff @(posedge Clock) begin
        if (!Reset && wr_acc && region == R_RAM) mem[ram_idx] <= bus_io.DataOut;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            din_q   <= '0;
            rdata_q <= '0;
            hex_q   <= {NUM_HEX{7'h7F}};
            led_q   <= '0;
            cap_q   <= '0;
        end else begin
            done_q <= 1'b0;
            // A press on the same edge as a clear leaves the bit set.
            cap_q  <= (cap_q & ~cap_clr) | key_rise;
            if (wr_acc && region == R_LED) led_q <= NUM_LED'(bus_io.DataOut);
            for (int i = 0; i < NUM_HEX; i++) begin
                if (wr_acc && region == R_HEX && hex_off == 32'(i)) begin
                    hex_q[i] <= bus_io.DataOut[6:0];
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        rd_q    <= rd_acc;
                        rdata_q <= rd_val;
                        if (region == R_RAM && RAM_LATENCY > 1) begin
                            state_q <= BUSY;
                            cnt_q   <= 4'd1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            if (rd_acc) din_q <= rd_val;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'(RAM_LATENCY - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (rd_q) din_q <= rdata_q;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.DataDone = done_q;
    assign bus_io.DataIn   = din_q;
    assign HEX             = hex_q;
    assign LEDR            = led_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed cases plus randomized traffic vs. a cycle model.
module tb_mmio_bridge;
    localparam int RAM_LATENCY = 2;
    localparam int NUM_HEX     = 6;
    localparam logic [15:0] RAM_TOP = 16'h1000;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic [5:0][6:0]  hex;
    logic [9:0]       ledr;
    logic [9:0]       sw  = '0;
    logic [3:0]       key = 4'hF;

    mmio_bridge_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mmio_bridge #(
        .DATA_W(16), .ADDR_W(16), .RAM_AW(12), .RAM_LATENCY(RAM_LATENCY),
        .NUM_HEX(NUM_HEX), .NUM_LED(10), .NUM_SW(10), .NUM_KEY(4)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus_io(bus),
        .HEX   (hex),
        .LEDR  (ledr),
        .SW    (sw),
        .KEY   (key)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              model_valid = 0;
    int              edge_n = 0;
    int              done_edge = -10;
    bit              pend_rd;
    logic [15:0]     pend_val;
    logic            m_done;
    logic [15:0]     m_din;
    logic [5:0][6:0] m_hex;
    logic [9:0]      m_led;
    logic [3:0]      m_cap;
    logic [3:0]      kh0, kh1, kh2;
    logic [9:0]      sh0, sh1;
    logic [31:0]     tmr;
    logic [15:0]     snap;
    logic [15:0]     m_mem [logic [15:0]];

    function automatic logic [15:0] model_read(input logic [15:0] a);
        logic [15:0] v;
        v = '0;
        if (a < RAM_TOP) v = m_mem.exists(a) ? m_mem[a] : 16'h0;
        for (int i = 0; i < NUM_HEX; i++) if (a == 16'hF000 + 16'(i)) v = {9'b0, m_hex[i]};
        if (a == 16'hF100) v = {6'b0, m_led};
        if (a == 16'hF200) v = {6'b0, sh1};
        if (a == 16'hF300) v = {12'b0, kh1};
        if (a == 16'hF301) v = {12'b0, m_cap};
`ifdef MMIO_TIMER_EN
        if (a == 16'hF400) v = tmr[15:0];
        if (a == 16'hF401) v = snap;
`endif
        return v;
    endfunction

    always @(posedge Clock) begin
        logic [15:0] a, d;
        logic [3:0]  rise, clr;
        logic [31:0] tnext;
        bit          wr, req;
        int          lat;
        edge_n++;
        a   = bus.DataAddr;
        d   = bus.DataOut;
        wr  = bus.WriteData;
        req = bus.ReadData | bus.WriteData;
        if (Reset) begin
            m_hex = {NUM_HEX{7'h7F}};
            m_led = '0; m_cap = '0; m_din = '0; m_done = 1'b0;
            done_edge = edge_n - 1; pend_rd = 0;
            kh0 = '0; kh1 = '0; kh2 = '0; sh0 = '0; sh1 = '0;
            tmr = '0; snap = '0;
            model_valid = 1;
        end else begin
            rise  = kh1 & ~kh2;
            clr   = '0;
            tnext = tmr + 32'd1;
            // Idle again two edges after the edge that entered DONE.
            if (req && edge_n >= done_edge + 2) begin
                lat = (a < RAM_TOP) ? RAM_LATENCY : 1;
                if (wr) begin
                    if (a < RAM_TOP) m_mem[a] = d;
                    for (int i = 0; i < NUM_HEX; i++)
                        if (a == 16'hF000 + 16'(i)) m_hex[i] = d[6:0];
                    if (a == 16'hF100) m_led = d[9:0];
                    if (a == 16'hF301) clr = d[3:0];
`ifdef MMIO_TIMER_EN
                    if (a == 16'hF400) tnext = '0;
`endif
                end else begin
                    pend_val = model_read(a);
`ifdef MMIO_TIMER_EN
                    if (a == 16'hF400) snap = tmr[31:16];
`endif
                end
                pend_rd   = !wr;
                done_edge = edge_n + lat - 1;
            end
            m_done = (edge_n == done_edge);
            if (m_done && pend_rd) m_din = pend_val;
            m_cap = (m_cap & ~clr) | rise;
            kh2 = kh1; kh1 = kh0; kh0 = ~key;
            sh1 = sh0; sh0 = sw;
            tmr = tnext;
        end
    end

    always @(negedge Clock) begin
        if (model_valid) begin
            chk("DataDone", 64'(bus.DataDone), 64'(m_done));
            chk("DataIn", 64'(bus.DataIn), 64'(m_din));
            chk("HEX", 64'(hex), 64'(m_hex));
            chk("LEDR", 64'(ledr), 64'(m_led));
        end
    end

    // ---------------- driver ----------------
    task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data, output logic [15:0] rdata, output int lat);
        @(negedge Clock);
        bus.ReadData  = rd;
        bus.WriteData = wr;
        bus.DataAddr  = addr;
        bus.DataOut   = data;
        lat = 0;
        do begin
            @(posedge Clock); #1;
            lat++;
        end while (!bus.DataDone && lat < 20);
        chk("done_timeout", 64'(bus.DataDone), 64'(1));
        rdata = bus.DataIn;
        @(posedge Clock); #1;
        bus.ReadData  = 1'b0;
        bus.WriteData = 1'b0;
    endtask

    logic [15:0] addr_pool [20] = '{16'h0000, 16'h0001, 16'h0010, 16'h0020, 16'h0FFF,
                                    16'h1000, 16'hF000, 16'hF003, 16'hF005, 16'hF006,
                                    16'hF100, 16'hF101, 16'hF200, 16'hF300, 16'hF301,
                                    16'hF302, 16'hF400, 16'hF401, 16'h8000, 16'hFFFF};

    initial begin
        logic [15:0] rv, a;
        int          lat, op;
        bus.ReadData = 0; bus.WriteData = 0; bus.DataAddr = '0; bus.DataOut = '0;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        chk("rst_done", 64'(bus.DataDone), 64'(0));
        chk("rst_din", 64'(bus.DataIn), 64'(0));
        chk("rst_hex", 64'(hex), 64'({6{7'h7F}}));
        chk("rst_ledr", 64'(ledr), 64'(0));

        access(0, 1, 16'h0010, 16'hABCD, rv, lat);
        chk("ram_wr_lat", 64'(lat), 64'(2));
        access(1, 0, 16'h0010, 16'h0000, rv, lat);
        chk("ram_rd_lat", 64'(lat), 64'(2));
        chk("ram_rd_data", 64'(rv), 64'(16'hABCD));

        access(0, 1, 16'hF003, 16'h0040, rv, lat);
        chk("hex_wr_lat", 64'(lat), 64'(1));
        for (int i = 0; i < NUM_HEX; i++)
            chk("hex_digit", 64'(hex[i]), 64'((i == 3) ? 7'h40 : 7'h7F));
        access(1, 0, 16'hF003, 16'h0000, rv, lat);
        chk("hex_rd", 64'(rv), 64'(16'h0040));
        access(0, 1, 16'hF000, 16'hFFC1, rv, lat);
        access(1, 0, 16'hF000, 16'h0000, rv, lat);
        chk("hex_trunc", 64'(rv), 64'(16'h0041));

        access(1, 1, 16'hF100, 16'hFFFF, rv, lat);
        chk("led_wr_both", 64'(ledr), 64'(10'h3FF));
        access(1, 0, 16'hF100, 16'h0000, rv, lat);
        chk("led_rd", 64'(rv), 64'(16'h03FF));

        sw = 10'h2A5;
        repeat (3) @(posedge Clock);
        access(1, 0, 16'hF200, 16'h0000, rv, lat);
        chk("sw_rd", 64'(rv), 64'(16'h02A5));

        @(negedge Clock) key[1] = 1'b0;
        repeat (4) @(posedge Clock);
        access(1, 0, 16'hF301, 16'h0000, rv, lat);
        chk("keycap_set", 64'(rv), 64'(16'h0002));
        access(0, 1, 16'hF301, 16'h0002, rv, lat);
        access(1, 0, 16'hF301, 16'h0000, rv, lat);
        chk("keycap_clr", 64'(rv), 64'(16'h0000));
        // Press KEY[2] so its capture edge coincides with a clear of the same bit.
        @(negedge Clock) key[2] = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        access(0, 1, 16'hF301, 16'h0004, rv, lat);
        access(1, 0, 16'hF301, 16'h0000, rv, lat);
        chk("keycap_set_wins", 64'(rv), 64'(16'h0004));
        access(1, 0, 16'hF300, 16'h0000, rv, lat);
        chk("key_level", 64'(rv), 64'(16'h0006));

        access(1, 0, 16'h8000, 16'h0000, rv, lat);
        chk("unmapped_lat", 64'(lat), 64'(1));
        chk("unmapped_rd", 64'(rv), 64'(0));

        access(0, 1, 16'h0020, 16'h1234, rv, lat);
        @(negedge Clock);
        bus.WriteData = 1; bus.DataAddr = 16'h0020; bus.DataOut = 16'hDEAD; Reset = 1;
        @(posedge Clock); #1;
        Reset = 0; bus.WriteData = 0;
        access(1, 0, 16'h0020, 16'h0000, rv, lat);
        chk("rst_blocks_write", 64'(rv), 64'(16'h1234));

        @(negedge Clock);
        bus.ReadData = 1; bus.DataAddr = 16'h0010;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1; bus.ReadData = 0;
        @(negedge Clock);
        Reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); #1;
            chk("abort_no_done", 64'(bus.DataDone), 64'(0));
        end
        chk("abort_din", 64'(bus.DataIn), 64'(0));
        access(1, 0, 16'h0010, 16'h0000, rv, lat);
        chk("after_abort_lat", 64'(lat), 64'(2));
        chk("after_abort_rd", 64'(rv), 64'(16'hABCD));

`ifdef MMIO_TIMER_EN
        access(0, 1, 16'hF400, 16'h0000, rv, lat);
        repeat (100) @(posedge Clock);
        access(1, 0, 16'hF400, 16'h0000, rv, lat);
        chk("timer_lo_min", 64'(rv >= 16'd100), 64'(1));
        chk("timer_lo_max", 64'(rv <= 16'd105), 64'(1));
        access(1, 0, 16'hF401, 16'h0000, rv, lat);
        chk("timer_hi", 64'(rv), 64'(0));
`endif

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) sw = 10'($urandom);
            if ($urandom_range(0, 2) == 0) key = key ^ 4'($urandom);
            a  = addr_pool[$urandom_range(0, 19)];
            op = $urandom_range(0, 9);
            if (op < 4 && a < RAM_TOP && !m_mem.exists(a)) op = 4;
            access(op < 4 || op > 7, op >= 4, a, 16'($urandom), rv, lat);
            repeat ($urandom_range(0, 2)) @(posedge Clock);
        end

        repeat (3) @(posedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
